// File: rtl/adder_tree_accum_ctrl.sv
// adder_tree_accum_ctrl: frame sequencer around an adder_tree2n reduction.
// Each accepted beat is reduced by the tree, and the beat sums are added up
// over a frame. The frame ends on in_last or after MAX_BEATS beats. The frame
// total is then held on a valid/ready output port until it is consumed.
// Optional macro ADDER_TREE_ACC_SAT_EN makes the accumulator saturate on
// overflow and raise the sticky out_ovf flag. Without the macro the
// accumulator wraps and out_ovf stays low.

// Balanced binary adder tree that sums TREE_SIZE lanes of A and TREE_SIZE lanes of B.
module adder_tree2n #(
    parameter int TREE_SIZE = 4,
    parameter int DATA_SIZE = 8,
    parameter int SUM_W     = DATA_SIZE + $clog2(TREE_SIZE) + 1
) (
    input  logic [TREE_SIZE*DATA_SIZE-1:0] i_a,
    input  logic [TREE_SIZE*DATA_SIZE-1:0] i_b,
    output logic [SUM_W-1:0]               o_sum
);
    localparam int LEAVES = 2 * TREE_SIZE;
    localparam int LEVELS = $clog2(LEAVES);

    // Level 0 holds every operand, zero-extended to the full sum width.
    // Each later level adds adjacent pairs from the level below it.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        logic [SUM_W-1:0] w_val [LEAVES >> l];
        if (l == 0) begin : g_leaves
            for (genvar j = 0; j < TREE_SIZE; j++) begin : g_lane
                assign w_val[j]             = SUM_W'(i_a[j*DATA_SIZE +: DATA_SIZE]);
                assign w_val[TREE_SIZE + j] = SUM_W'(i_b[j*DATA_SIZE +: DATA_SIZE]);
            end
        end else begin : g_adders
            for (genvar i = 0; i < (LEAVES >> l); i++) begin : g_add
                assign w_val[i] = g_lvl[l-1].w_val[2*i] + g_lvl[l-1].w_val[2*i+1];
            end
        end
    end

    assign o_sum = g_lvl[LEVELS].w_val[0];
endmodule

module adder_tree_accum_ctrl #(
    parameter int TREE_SIZE = 4,
    parameter int DATA_SIZE = 8,
    parameter int ACC_W     = 24,
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_last,
    input  logic [TREE_SIZE*DATA_SIZE-1:0] in_a,
    input  logic [TREE_SIZE*DATA_SIZE-1:0] in_b,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ACC_W-1:0]               out_sum,
    output logic [CNT_W-1:0]               out_beats,
    output logic                           out_trunc,
    output logic                           out_ovf,
    output logic                           busy
);
    localparam int SUM_W = DATA_SIZE + $clog2(TREE_SIZE) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_trunc;
`ifdef ADDER_TREE_ACC_SAT_EN
    logic             r_sat;
    logic [ACC_W:0]   w_accSum;
`else
    logic [ACC_W-1:0] w_accSum;
`endif

    logic [SUM_W-1:0] w_beatSum;
    logic [ACC_W-1:0] w_beatExt;
    logic             w_inReady;
    logic             w_accept;
    logic [CNT_W-1:0] w_cntNext;
    logic             w_limit;
    logic             w_frameEnd;

    adder_tree2n #(
        .TREE_SIZE (TREE_SIZE),
        .DATA_SIZE (DATA_SIZE),
        .SUM_W     (SUM_W)
    ) u_tree (
        .i_a   (in_a),
        .i_b   (in_b),
        .o_sum (w_beatSum)
    );

    assign w_beatExt  = ACC_W'(w_beatSum);
    assign w_inReady  = (r_state != S_DONE);
    assign in_ready   = w_inReady;
    assign w_accept   = in_valid & w_inReady;
    // The first beat of a frame always counts as one. That makes the beat
    // limit check the same in IDLE and in ACCUM.
    assign w_cntNext  = (r_state == S_IDLE) ? CNT_W'(1) : r_cnt + CNT_W'(1);
    assign w_limit    = (w_cntNext == MAX_CNT);
    assign w_frameEnd = w_accept & (in_last | w_limit);
`ifdef ADDER_TREE_ACC_SAT_EN
    assign w_accSum   = {1'b0, r_acc} + {1'b0, w_beatExt};
`else
    assign w_accSum   = r_acc + w_beatExt;
`endif

    // Hold the frame state and move to the next state on each clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Choose the next state and drive the result port. The result fields read as zero outside DONE.
    always_comb begin
        w_stateNext = r_state;
        out_valid   = 1'b0;
        busy        = 1'b0;
        out_sum     = '0;
        out_beats   = '0;
        out_trunc   = 1'b0;
        out_ovf     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_stateNext = w_frameEnd ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                busy = 1'b1;
                if (w_frameEnd) begin
                    w_stateNext = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_sum   = r_acc;
                out_beats = r_cnt;
                out_trunc = r_trunc;
`ifdef ADDER_TREE_ACC_SAT_EN
                out_ovf   = r_sat;
`endif
                if (out_ready) begin
                    w_stateNext = S_IDLE;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // Accumulate beat sums and the beat count for the frame. Record why the
    // frame ended, and clear everything once the result has been consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_trunc <= 1'b0;
`ifdef ADDER_TREE_ACC_SAT_EN
            r_sat   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_acc   <= w_beatExt;
                        r_cnt   <= w_cntNext;
                        r_trunc <= w_limit & ~in_last;
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
`ifdef ADDER_TREE_ACC_SAT_EN
                        if (r_sat | w_accSum[ACC_W]) begin
                            r_acc <= '1;
                            r_sat <= 1'b1;
                        end else begin
                            r_acc <= w_accSum[ACC_W-1:0];
                        end
`else
                        r_acc   <= w_accSum;
`endif
                        r_cnt   <= w_cntNext;
                        r_trunc <= w_limit & ~in_last;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_trunc <= 1'b0;
`ifdef ADDER_TREE_ACC_SAT_EN
                        r_sat   <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_acc <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adder_tree_accum_ctrl.sv
// Testbench for adder_tree_accum_ctrl. It uses two instances:
// - dut0 runs with the default parameters.
// - dut1 runs with ACC_W=12 and MAX_BEATS=4, so truncation and overflow are
//   reachable in a few beats.
// A frame-level model predicts every result, and the outputs are compared
// against it on every falling edge. Directed literal checks pin the model.
module tb_adder_tree_accum_ctrl;

    typedef struct {
        longint sum;
        int     beats;
        bit     trunc;
        bit     ovf;
    } result_t;

`ifdef ADDER_TREE_ACC_SAT_EN
    localparam bit SAT_MODE = 1'b1;
`else
    localparam bit SAT_MODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inValid  [2];
    logic        inLast   [2];
    logic        outReady [2];
    logic [31:0] inA      [2];
    logic [31:0] inB      [2];
    logic        inReady  [2];
    logic        outValid [2];
    logic        outTrunc [2];
    logic        outOvf   [2];
    logic        busy     [2];
    logic [23:0] outSum0;
    logic [11:0] outSum1;
    logic [4:0]  outBeats0;
    logic [2:0]  outBeats1;

    int      vectors     = 0;
    int      miscompares = 0;
    longint  mSum    [2];
    int      mCnt    [2];
    bit      pend    [2];
    result_t pendRes [2];
    bit      started = 1'b0;

    always #5 clk = ~clk;

    adder_tree_accum_ctrl dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid[0]),
        .in_ready  (inReady[0]),
        .in_last   (inLast[0]),
        .in_a      (inA[0]),
        .in_b      (inB[0]),
        .out_valid (outValid[0]),
        .out_ready (outReady[0]),
        .out_sum   (outSum0),
        .out_beats (outBeats0),
        .out_trunc (outTrunc[0]),
        .out_ovf   (outOvf[0]),
        .busy      (busy[0])
    );

    adder_tree_accum_ctrl #(
        .ACC_W     (12),
        .MAX_BEATS (4)
    ) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid[1]),
        .in_ready  (inReady[1]),
        .in_last   (inLast[1]),
        .in_a      (inA[1]),
        .in_b      (inB[1]),
        .out_valid (outValid[1]),
        .out_ready (outReady[1]),
        .out_sum   (outSum1),
        .out_beats (outBeats1),
        .out_trunc (outTrunc[1]),
        .out_ovf   (outOvf[1]),
        .busy      (busy[1])
    );

    function automatic longint dutSum(input int d);
        return (d == 0) ? longint'(outSum0) : longint'(outSum1);
    endfunction

    function automatic longint dutBeats(input int d);
        return (d == 0) ? longint'(outBeats0) : longint'(outBeats1);
    endfunction

    // Beat value as plain arithmetic: the sum of all eight byte operands.
    function automatic longint laneSum(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = 0;
        for (int j = 0; j < 4; j++) begin
            s += longint'(a[j*8 +: 8]) + longint'(b[j*8 +: 8]);
        end
        return s;
    endfunction

    task automatic compareValue(input string name, input longint actual, input longint expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Compare one instance against the model, then advance the model by one edge.
    task automatic checkOutput(input int d);
        int     maxBeats;
        longint maxVal;
        bit     accept;
        maxBeats = (d == 0) ? 16 : 4;
        maxVal   = (d == 0) ? 64'd16777215 : 64'd4095;
        if (started) begin
            compareValue($sformatf("dut%0d out_valid", d), longint'(outValid[d]), longint'(pend[d]));
            compareValue($sformatf("dut%0d in_ready", d), longint'(inReady[d]), longint'(!pend[d]));
            compareValue($sformatf("dut%0d busy", d), longint'(busy[d]), longint'(pend[d] || mCnt[d] > 0));
            if (pend[d] && outValid[d] === 1'b1) begin
                compareValue($sformatf("dut%0d out_sum", d), dutSum(d), pendRes[d].sum);
                compareValue($sformatf("dut%0d out_beats", d), dutBeats(d), longint'(pendRes[d].beats));
                compareValue($sformatf("dut%0d out_trunc", d), longint'(outTrunc[d]), longint'(pendRes[d].trunc));
                compareValue($sformatf("dut%0d out_ovf", d), longint'(outOvf[d]), longint'(pendRes[d].ovf));
            end
        end
        if (rst_n !== 1'b1) begin
            mSum[d] = 0;
            mCnt[d] = 0;
            pend[d] = 1'b0;
            started = 1'b1;
            return;
        end
        accept = (inValid[d] === 1'b1) && !pend[d];
        if (pend[d] && outReady[d] === 1'b1) begin
            pend[d] = 1'b0;
        end
        if (accept) begin
            mSum[d] += laneSum(inA[d], inB[d]);
            mCnt[d]++;
            if (inLast[d] === 1'b1 || mCnt[d] == maxBeats) begin
                pendRes[d].beats = mCnt[d];
                pendRes[d].trunc = (inLast[d] !== 1'b1);
                pendRes[d].ovf   = SAT_MODE && (mSum[d] > maxVal);
                if (mSum[d] > maxVal) begin
                    pendRes[d].sum = SAT_MODE ? maxVal : (mSum[d] % (maxVal + 1));
                end else begin
                    pendRes[d].sum = mSum[d];
                end
                pend[d] = 1'b1;
                mSum[d] = 0;
                mCnt[d] = 0;
            end
        end
    endtask

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin
        checkOutput(0);
        checkOutput(1);
    end

    // Offer one beat and hold it until it is accepted. The task is entered and
    // left just after a rising edge.
    task automatic applyStimulus(input int d, input logic [31:0] a, input logic [31:0] b, input logic last);
        int waitCnt;
        waitCnt    = 0;
        inValid[d] = 1'b1;
        inA[d]     = a;
        inB[d]     = b;
        inLast[d]  = last;
        @(negedge clk);
        while (inReady[d] !== 1'b1 && waitCnt < 50) begin
            waitCnt++;
            @(negedge clk);
        end
        if (waitCnt >= 50) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL dut%0d beat accept timeout: got no in_ready, expected in_ready=1", d);
        end
        @(posedge clk);
        #1;
        inValid[d] = 1'b0;
        inLast[d]  = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected $finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            inValid[d]  = 1'b0;
            inLast[d]   = 1'b0;
            inA[d]      = '0;
            inB[d]      = '0;
            outReady[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] reset state");
        compareValue("reset out_valid", longint'(outValid[0]), 0);
        compareValue("reset out_sum", dutSum(0), 0);
        compareValue("reset out_beats", dutBeats(0), 0);
        compareValue("reset out_trunc", longint'(outTrunc[0]), 0);
        compareValue("reset out_ovf", longint'(outOvf[0]), 0);
        compareValue("reset in_ready", longint'(inReady[0]), 1);
        compareValue("reset busy", longint'(busy[0]), 0);
        compareValue("reset dut1 out_valid", longint'(outValid[1]), 0);

        $display("[TB] three full-scale beats");
        applyStimulus(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        applyStimulus(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        applyStimulus(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        compareValue("t1 out_valid", longint'(outValid[0]), 1);
        compareValue("t1 out_sum", dutSum(0), 6120);
        compareValue("t1 out_beats", dutBeats(0), 3);
        compareValue("t1 out_trunc", longint'(outTrunc[0]), 0);
        compareValue("t1 in_ready", longint'(inReady[0]), 0);
        idleCycles(1);
        compareValue("t1 out_valid after", longint'(outValid[0]), 0);
        compareValue("t1 in_ready after", longint'(inReady[0]), 1);

        $display("[TB] single-beat frame");
        applyStimulus(0, 32'h04030201, 32'h281E140A, 1'b1);
        compareValue("t2 out_sum", dutSum(0), 110);
        compareValue("t2 out_beats", dutBeats(0), 1);
        idleCycles(2);

        $display("[TB] beat limit on small instance");
        for (int i = 0; i < 4; i++) applyStimulus(1, 32'h00000019, 32'h0000004B, 1'b0);
        compareValue("t3 out_sum", dutSum(1), 400);
        compareValue("t3 out_beats", dutBeats(1), 4);
        compareValue("t3 out_trunc", longint'(outTrunc[1]), 1);
        applyStimulus(1, 32'h00000019, 32'h0000004B, 1'b0);
        applyStimulus(1, 32'h00000019, 32'h0000004B, 1'b0);
        applyStimulus(1, 32'h00000019, 32'h0000004B, 1'b1);
        compareValue("t3b out_sum", dutSum(1), 300);
        compareValue("t3b out_beats", dutBeats(1), 3);
        compareValue("t3b out_trunc", longint'(outTrunc[1]), 0);
        idleCycles(2);
        for (int i = 0; i < 3; i++) applyStimulus(1, 32'h00000019, 32'h0000004B, 1'b0);
        applyStimulus(1, 32'h00000019, 32'h0000004B, 1'b1);
        compareValue("t3c last on limit out_trunc", longint'(outTrunc[1]), 0);
        compareValue("t3c out_beats", dutBeats(1), 4);
        idleCycles(2);

        $display("[TB] accumulator overflow");
        applyStimulus(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        applyStimulus(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        applyStimulus(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        compareValue("t4 out_sum", dutSum(1), SAT_MODE ? 4095 : 2024);
        compareValue("t4 out_ovf", longint'(outOvf[1]), SAT_MODE ? 1 : 0);
        idleCycles(2);

        $display("[TB] consumer back-pressure");
        outReady[0] = 1'b0;
        applyStimulus(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        applyStimulus(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        inValid[0] = 1'b1;
        inA[0]     = 32'h04030201;
        inB[0]     = 32'h281E140A;
        inLast[0]  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            compareValue("t5 hold out_valid", longint'(outValid[0]), 1);
            compareValue("t5 hold out_sum", dutSum(0), 4080);
            compareValue("t5 hold out_beats", dutBeats(0), 2);
            compareValue("t5 hold in_ready", longint'(inReady[0]), 0);
            idleCycles(1);
        end
        outReady[0] = 1'b1;
        applyStimulus(0, 32'h04030201, 32'h281E140A, 1'b1);
        compareValue("t5 next out_sum", dutSum(0), 110);
        compareValue("t5 next out_beats", dutBeats(0), 1);
        idleCycles(2);

        $display("[TB] reset mid-frame");
        applyStimulus(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        applyStimulus(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        rst_n = 1'b0;
        idleCycles(1);
        rst_n = 1'b1;
        compareValue("t6 out_valid", longint'(outValid[0]), 0);
        compareValue("t6 out_sum", dutSum(0), 0);
        compareValue("t6 out_beats", dutBeats(0), 0);
        compareValue("t6 busy", longint'(busy[0]), 0);
        compareValue("t6 in_ready", longint'(inReady[0]), 1);
        applyStimulus(0, 32'h00000019, 32'h00000019, 1'b1);
        compareValue("t6 out_sum after", dutSum(0), 50);
        compareValue("t6 out_beats after", dutBeats(0), 1);
        idleCycles(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/adder_tree_accum_ctrl.md
Name: adder_tree_accum_ctrl

Overview:
Frame sequencer for the adder_tree2n reduction datapath. It accepts a stream of beats, each carrying TREE_SIZE operand pairs, and reduces each beat through one internal adder_tree2n instance. It accumulates the per-beat sums across a frame delimited by in_last or by the MAX_BEATS limit. It then presents the frame total on a valid/ready output port. It sits between a streaming operand source and any consumer of reduced sums (e.g. dot-product or checksum logic).

Parameters:
TREE_SIZE, 4, operand pairs per beat; power of 2, >= 2
DATA_SIZE, 8, bits per operand
ACC_W, 24, accumulator/result width; must be >= DATA_SIZE+$clog2(TREE_SIZE)+1
MAX_BEATS, 16, maximum beats per frame before forced termination
CNT_W, $clog2(MAX_BEATS+1), derived beat-counter width

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  synchronous, active-low reset
in_valid  in  1  beat offered
in_ready  out  1  block can accept a beat
in_last  in  1  final beat of frame; qualified by in_valid
in_a  in  TREE_SIZE*DATA_SIZE  operand set A, lane j = bits [(j+1)*DATA_SIZE-1 : j*DATA_SIZE]
in_b  in  TREE_SIZE*DATA_SIZE  operand set B, same lane layout
out_valid  out  1  frame result available
out_ready  in  1  consumer accepts result
out_sum  out  ACC_W  frame total
out_beats  out  CNT_W  beats accumulated in the frame
out_trunc  out  1  frame ended by MAX_BEATS without in_last
out_ovf  out  1  accumulator overflow occurred (see Optional Feature)
busy  out  1  high in ACCUM or DONE

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; acc=0; cnt=0
  - out_valid=0, out_sum=0, out_beats=0, out_trunc=0, out_ovf=0, busy=0
  - in_ready=1 from the first cycle after reset
  - reset mid-frame discards the partial frame; no output is produced for it
- Beat sum: S = zero-extension to ACC_W of the adder_tree2n output (width DATA_SIZE+$clog2(TREE_SIZE)+1, unsigned). The tree is purely combinational from in_a/in_b.
- Accept = in_valid & in_ready. in_ready = (state != DONE).
- IDLE:
  - on accept: acc<=S, cnt<=1
  - if in_last, or MAX_BEATS==1: go to DONE
  - otherwise go to ACCUM
- ACCUM:
  - on accept: acc<=acc+S, cnt<=cnt+1
  - go to DONE if in_last, or if cnt+1==MAX_BEATS
  - no accept: hold all state
- Truncation flag: on entry to DONE, out_trunc<=1 only when the MAX_BEATS limit was reached and in_last was 0 on the final beat. in_last arriving exactly on beat MAX_BEATS gives out_trunc=0.
- DONE:
  - out_valid=1; out_sum=acc; out_beats=cnt; in_ready=0
  - on out_valid & out_ready: go to IDLE, acc<=0, cnt<=0
  - the next beat can be accepted in the cycle after the handshake (one bubble)
  - out_* fields stay stable while out_valid=1 and out_ready=0
- Latency: result valid the cycle after the last beat is accepted. Worst-case throughput is N beats per N+1 cycles with out_ready held high.
- in_a/in_b/in_last are ignored when in_valid=0 or in_ready=0.
- Width of the accumulation: acc+S is computed ACC_W+1 wide; carry-out indicates overflow.

Optional Feature:
Macro ADDER_TREE_ACC_SAT_EN.
- Defined:
  - on carry-out, acc<=all ones (2^ACC_W-1) and stays saturated for the rest of the frame
  - out_ovf is sticky per frame, set in DONE if any saturation occurred, and cleared on return to IDLE
- Undefined:
  - acc wraps modulo 2^ACC_W
  - out_ovf is tied 0
  - no saturation logic is synthesised

Test Plan:
- Default params; 3 beats, all lanes A=0xFF, B=0xFF, in_last on beat 3, out_ready=1 → out_valid exactly 1 cycle after beat 3; out_sum=6120, out_beats=3, out_trunc=0; in_ready low for that one cycle.
- Single beat with lanes A={1,2,3,4}, B={10,20,30,40}, in_last=1 → out_sum=110, out_beats=1; direct IDLE→DONE.
- MAX_BEATS=4; 6 beats each summing to 100, in_last never set → first result out_sum=400, out_beats=4, out_trunc=1. Remaining 2 beats start a new frame.
- ACC_W=12; 3 beats of 2040 → without macro out_sum=2024, out_ovf=0; with ADDER_TREE_ACC_SAT_EN out_sum=4095, out_ovf=1.
- out_ready held 0 for 5 cycles in DONE → out_valid stays 1, out_sum/out_beats stable, in_ready=0, in_valid beats not consumed; accepted after out_ready=1.
- rst_n=0 for 1 cycle after 2 beats of a frame → all outputs 0, state IDLE. A following 1-beat frame with sum 50 yields out_sum=50, out_beats=1.
